// File: rtl/tpmem_gen.sv
// tpmem_gen: ping-pong N x N block transposer. Rows stream in on
// i_data/i_valid/o_ready; columns stream out on o_data/o_valid/i_ready,
// with o_last flagging column N-1 of each block.
// Ports: i_clk, i_Reset (sync, active-high), i_data, i_valid, o_ready,
//        o_data, o_valid, i_ready, o_last; i_bypass when built with
//        TPMEM_GEN_BYPASS_EN (bypass-tagged banks are emitted row by row).
module tpmem_gen #(
   parameter int BW = 8,
   parameter int N  = 8
) (
   input  logic          i_clk,
   input  logic          i_Reset,
   input  logic [N*BW-1:0] i_data,
   input  logic          i_valid,
   output logic          o_ready,
`ifdef TPMEM_GEN_BYPASS_EN
   input  logic          i_bypass,
`endif
   output logic [N*BW-1:0] o_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_last
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL
   } bank_st_e;

   bank_st_e st_q [2];
   bank_st_e st_d [2];
   logic            wb_q, wb_d;
   logic            rb_q, rb_d;
   logic [CW-1:0]   wr_row_q, wr_row_d;
   logic [CW-1:0]   rd_col_q, rd_col_d;
   logic [N*BW-1:0] o_data_q, o_data_d;
   logic            o_valid_q, o_valid_d;
   logic            o_last_q, o_last_d;
`ifdef TPMEM_GEN_BYPASS_EN
   logic [1:0]      byp_q, byp_d;
`endif

   // Bank storage carries no reset; bank state alone decides validity.
   logic [N*BW-1:0] mem_q [2][N];

   logic            accept;
   logic            load;
   logic [N*BW-1:0] col;

   assign o_ready = (st_q[wb_q] != FULL);
   assign accept  = i_valid && o_ready;
   assign load    = (st_q[rb_q] == FULL) && (!o_valid_q || i_ready);

   // Column rd_col: lane r takes lane rd_col of stored row r.
   always_comb begin
      int c;
      col = '0;
      c   = int'(rd_col_q);
      for (int r = 0; r < N; r++) begin
         col[(N-r)*BW-1 -: BW] = mem_q[rb_q][r][(N-c)*BW-1 -: BW];
      end
`ifdef TPMEM_GEN_BYPASS_EN
      if (byp_q[rb_q]) begin
         col = mem_q[rb_q][rd_col_q];
      end
`endif
   end

   always_comb begin
      st_d      = st_q;
      wb_d      = wb_q;
      rb_d      = rb_q;
      wr_row_d  = wr_row_q;
      rd_col_d  = rd_col_q;
      o_data_d  = o_data_q;
      o_valid_d = o_valid_q;
      o_last_d  = o_last_q;
`ifdef TPMEM_GEN_BYPASS_EN
      byp_d     = byp_q;
      if (accept && wr_row_q == '0) begin
         byp_d[wb_q] = i_bypass;
      end
`endif
      if (accept) begin
         if (wr_row_q == CW'(N-1)) begin
            st_d[wb_q] = FULL;
            wb_d       = ~wb_q;
            wr_row_d   = '0;
         end else begin
            st_d[wb_q] = FILLING;
            wr_row_d   = wr_row_q + CW'(1);
         end
      end
      // Write bank is never FULL and read bank only loads when FULL,
      // so the two state updates always target different banks.
      if (load) begin
         o_data_d  = col;
         o_valid_d = 1'b1;
         o_last_d  = (rd_col_q == CW'(N-1));
         if (rd_col_q == CW'(N-1)) begin
            st_d[rb_q] = EMPTY;
            rb_d       = ~rb_q;
            rd_col_d   = '0;
         end else begin
            rd_col_d   = rd_col_q + CW'(1);
         end
      end else if (o_valid_q && i_ready) begin
         o_valid_d = 1'b0;
         o_last_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_Reset) begin
         st_q[0]   <= EMPTY;
         st_q[1]   <= EMPTY;
         wb_q      <= 1'b0;
         rb_q      <= 1'b0;
         wr_row_q  <= '0;
         rd_col_q  <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
`ifdef TPMEM_GEN_BYPASS_EN
         byp_q     <= '0;
`endif
      end else begin
         st_q      <= st_d;
         wb_q      <= wb_d;
         rb_q      <= rb_d;
         wr_row_q  <= wr_row_d;
         rd_col_q  <= rd_col_d;
         o_data_q  <= o_data_d;
         o_valid_q <= o_valid_d;
         o_last_q  <= o_last_d;
`ifdef TPMEM_GEN_BYPASS_EN
         byp_q     <= byp_d;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         mem_q[wb_q][wr_row_q] <= i_data;
      end
   end

   assign o_data  = o_data_q;
   assign o_valid = o_valid_q;
   assign o_last  = o_last_q;

endmodule

// File: tb/tb_tpmem_gen.sv
// tb_tpmem_gen: directed bench for tpmem_gen with N=8, BW=8.
// Rows carry lane k = b*64 + 8r + k so every element is unique.
module tb_tpmem_gen;

   localparam int BW = 8;
   localparam int N  = 8;

   logic            i_clk = 1'b0;
   logic            i_Reset = 1'b1;
   logic [N*BW-1:0] i_data = '0;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic            i_bypass = 1'b0;
   logic [N*BW-1:0] o_data;
   logic            o_valid;
   logic            i_ready = 1'b0;
   logic            o_last;

   int errors = 0;
   int checks = 0;

   tpmem_gen #(.BW(BW), .N(N)) dut (
      .i_clk   (i_clk),
      .i_Reset (i_Reset),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
`ifdef TPMEM_GEN_BYPASS_EN
      .i_bypass(i_bypass),
`endif
      .o_data  (o_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_last  (o_last)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [N*BW-1:0] row_val(int b, int r);
      logic [N*BW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[(N-k)*BW-1 -: BW] = 8'(b*64 + 8*r + k);
      return v;
   endfunction

   function automatic logic [N*BW-1:0] col_val(int b, int c);
      logic [N*BW-1:0] v;
      v = '0;
      for (int r = 0; r < N; r++) v[(N-r)*BW-1 -: BW] = 8'(b*64 + 8*r + c);
      return v;
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_Reset = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      step();
      step();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL rst_o_valid got=%b exp=0", o_valid);
      end
      checks++;
      if (o_last !== 1'b0) begin
         errors++; $display("FAIL rst_o_last got=%b exp=0", o_last);
      end
      checks++;
      if (o_data !== '0) begin
         errors++; $display("FAIL rst_o_data got=%h exp=0", o_data);
      end
      checks++;
      if (o_ready !== 1'b1) begin
         errors++; $display("FAIL rst_o_ready got=%b exp=1", o_ready);
      end
      i_Reset = 1'b0;
   endtask

   task automatic test_transpose(input int blk);
      i_ready = 1'b1;
      for (int r = 0; r < N; r++) begin
         i_valid = 1'b1;
         i_data  = row_val(blk, r);
         step();
      end
      i_valid = 1'b0;
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL tp_early_valid got=%b exp=0", o_valid);
      end
      for (int c = 0; c < N; c++) begin
         step();
         checks++;
         if (o_valid !== 1'b1 || o_data !== col_val(blk, c)
             || o_last !== (c == N-1)) begin
            errors++;
            $display("FAIL tp_col%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                     c, o_valid, o_data, o_last, col_val(blk, c), c == N-1);
         end
      end
      step();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++; $display("FAIL tp_drain_valid got=%b exp=0", o_valid);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      int gaps = 0;
      int first = -1;
      i_ready = 1'b1;
      for (int k = 0; k < 34; k++) begin
         i_valid = (k < 24);
         i_data  = row_val(k / 8, k % 8);
         if (k < 24) begin
            checks++;
            if (o_ready !== 1'b1) begin
               errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, o_ready);
            end
         end
         step();
         if (o_valid === 1'b1 && n < 24) begin
            if (first < 0) first = k;
            checks++;
            if (o_data !== col_val(n / 8, n % 8) || o_last !== (n % 8 == 7)) begin
               errors++;
               $display("FAIL b2b_col%0d got d=%h l=%b exp d=%h l=%b",
                        n, o_data, o_last, col_val(n / 8, n % 8), n % 8 == 7);
            end
            n++;
         end else if (n > 0 && n < 24) begin
            gaps++;
         end
      end
      i_valid = 1'b0;
      checks++;
      if (n != 24 || gaps != 0 || first != 8) begin
         errors++;
         $display("FAIL b2b_stream got n=%0d gaps=%0d first=%0d exp 24 0 8",
                  n, gaps, first);
      end
   endtask

   task automatic test_backpressure();
      i_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         i_valid = 1'b1;
         i_data  = row_val(k / 8, k % 8);
         checks++;
         if (o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready k=%0d got=%b exp=1", k, o_ready);
         end
         step();
      end
      i_valid = 1'b0;
      checks++;
      if (o_ready !== 1'b0) begin
         errors++; $display("FAIL bp_full_ready got=%b exp=0", o_ready);
      end
      step();
      step();
      checks++;
      if (o_valid !== 1'b1 || o_data !== col_val(0, 0) || o_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_frozen got v=%b d=%h r=%b exp v=1 d=%h r=0",
                  o_valid, o_data, o_ready, col_val(0, 0));
      end
      i_ready = 1'b1;
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (o_valid !== 1'b1 || o_data !== col_val(n / 8, n % 8)
             || o_last !== (n % 8 == 7)) begin
            errors++;
            $display("FAIL bp_drain%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                     n, o_valid, o_data, o_last, col_val(n / 8, n % 8), n % 8 == 7);
         end
         step();
      end
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_end got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
      end
   endtask

   task automatic test_reset_mid();
      i_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         i_valid = 1'b1;
         i_data  = row_val(3, r);
         step();
      end
      i_valid = 1'b0;
      i_Reset = 1'b1;
      step();
      i_Reset = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
      end
      test_transpose(1);
   endtask

   task automatic test_toggle();
      int idx = 0;
      logic [N*BW-1:0] held;
      i_ready = 1'b1;
      for (int r = 0; r < N; r++) begin
         i_valid = 1'b1;
         i_data  = row_val(2, r);
         step();
      end
      i_valid = 1'b0;
      for (int cyc = 0; cyc < 40 && idx < N; cyc++) begin
         i_ready = (cyc % 2 == 0);
         held = o_data;
         if (o_valid === 1'b1 && i_ready) begin
            checks++;
            if (o_data !== col_val(2, idx) || o_last !== (idx == N-1)) begin
               errors++;
               $display("FAIL tog_col%0d got d=%h l=%b exp d=%h l=%b",
                        idx, o_data, o_last, col_val(2, idx), idx == N-1);
            end
            idx++;
            step();
         end else if (o_valid === 1'b1) begin
            step();
            checks++;
            if (o_valid !== 1'b1 || o_data !== held) begin
               errors++;
               $display("FAIL tog_hold got v=%b d=%h exp v=1 d=%h",
                        o_valid, o_data, held);
            end
         end else begin
            step();
         end
      end
      i_ready = 1'b1;
      step();
      checks++;
      if (idx != N || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL tog_count got n=%0d v=%b exp n=%0d v=0", idx, o_valid, N);
      end
   endtask

`ifdef TPMEM_GEN_BYPASS_EN
   task automatic test_bypass();
      int n = 0;
      logic [N*BW-1:0] exp_d;
      i_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         i_valid  = (k < 16);
         i_data   = row_val(k / 8, k % 8);
         i_bypass = (k < 8);
         step();
         if (o_valid === 1'b1 && n < 16) begin
            exp_d = (n < 8) ? row_val(0, n) : col_val(1, n - 8);
            checks++;
            if (o_data !== exp_d || o_last !== (n % 8 == 7)) begin
               errors++;
               $display("FAIL byp_out%0d got d=%h l=%b exp d=%h l=%b",
                        n, o_data, o_last, exp_d, n % 8 == 7);
            end
            n++;
         end
      end
      i_valid  = 1'b0;
      i_bypass = 1'b0;
      checks++;
      if (n != 16) begin
         errors++; $display("FAIL byp_count got=%0d exp=16", n);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_transpose(0);
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_toggle();
`ifdef TPMEM_GEN_BYPASS_EN
      test_bypass();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tpmem_gen.md
TPMEM_GEN -- requirements
Module: tpmem_gen

Interface
REQ-001 SHALL have parameter BW, default 8, bits per element (legal 1..32).
REQ-002 SHALL have parameter N, default 8, block dimension, N×N elements per block (legal 2..16).
REQ-003 SHALL have input i_clk, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have input i_Reset, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have input i_data, N*BW bits: one input row; lane k in bits [(N-k)*BW-1 -: BW], so lane 0 is the MSB lane.
REQ-006 SHALL have input i_valid, 1 bit: i_data holds a valid row.
REQ-007 SHALL have output o_ready, 1 bit: block can accept a row this cycle.
REQ-008 SHALL have output o_data, N*BW bits: one output column, same lane packing as i_data.
REQ-009 SHALL have output o_valid, 1 bit: o_data holds a valid column.
REQ-010 SHALL have input i_ready, 1 bit: downstream accepts o_data this cycle.
REQ-011 SHALL have output o_last, 1 bit: the current o_data is column N-1 of a block.

Function
REQ-012 SHALL store data in two N×N banks (ping-pong), each in state EMPTY, FILLING or FULL.
REQ-013 SHALL accept a row on an edge where i_valid && o_ready, writing it to row wr_row of write bank wb; wr_row then increments.
REQ-014 SHALL mark bank wb FULL, toggle wb and clear wr_row to 0 on the edge that accepts row N-1.
REQ-015 SHALL drive o_ready = 1 iff bank wb is not FULL (combinational, no dependence on i_valid).
REQ-016 SHALL, on the read side, load the output register with column rd_col of read bank rb whenever bank rb is FULL and (!o_valid || i_ready).
REQ-017 SHALL form output column c so that lane r = element (row r, lane c) of the stored block.
REQ-018 SHALL make o_data, o_valid and o_last registered outputs that are held stable while o_valid && !i_ready.
REQ-019 SHALL, when column N-1 is loaded, set o_last, mark bank rb EMPTY, toggle rb and clear rd_col on that same edge.
REQ-020 SHALL set latency so that if row N-1 is accepted at edge E and the output register is free, o_valid=1 with column 0 at edge E+1.
REQ-021 SHALL sustain full throughput: with i_valid=1 and i_ready=1 continuously, one row in and one column out per cycle, with no bubbles after the first block.
REQ-022 SHALL, when a bank is freed and the other bank is filled on the same edge, apply both updates; o_ready stays 1.
REQ-023 SHALL, when both banks are FULL, hold o_ready=0 until the read side frees a bank; no row is dropped or overwritten.
REQ-024 SHALL clear o_valid on an edge where o_valid && i_ready and no FULL bank is available.
REQ-025 SHALL wrap wr_row, rd_col, wb and rb modulo N and 2 respectively; counters are sized to ceil(log2 N) bits.

Reset
REQ-026 SHALL, while i_Reset=1 at an edge, set both banks EMPTY, wb=rb=0, wr_row=rd_col=0, o_valid=0, o_last=0, o_data=0.
REQ-027 SHALL, on reset mid-block, discard all partial and full blocks; o_ready=1 on the first cycle after reset deasserts.
REQ-028 SHALL not require bank storage contents to be reset.

Configuration
REQ-029 SHALL, when macro TPMEM_GEN_BYPASS_EN is defined, add input i_bypass (1 bit), sampled when row 0 of a block is accepted and stored per bank.
REQ-030 SHALL, for a bank tagged bypass, output stored rows in row order (o_data = row rd_col, untransposed), with identical handshake, latency and o_last.
REQ-031 SHALL, when TPMEM_GEN_BYPASS_EN is undefined, omit port i_bypass and always transpose.

Verification (N=8, BW=8)
REQ-032 SHALL check: rows r with lane k = 8r+k, i_valid=1, i_ready=1 -> columns c with lane r = 8r+c; o_valid at edge after row 7; o_last on column 7.
REQ-033 SHALL check: 3 back-to-back blocks with i_ready=1 -> 24 consecutive o_valid cycles, no gaps, o_ready never 0.
REQ-034 SHALL check: i_ready=0 while 16 rows are offered -> o_ready=0 after row 15; o_data frozen on column 0 of block 0; raising i_ready drains 16 columns in order.
REQ-035 SHALL check: reset asserted after row 4 of a block -> o_valid=0, o_ready=1 afterwards; the next full block is output correctly with no residue.
REQ-036 SHALL check: i_ready toggling 1010... during output -> each column is presented until accepted; none are lost or duplicated.
REQ-037 SHALL check, with TPMEM_GEN_BYPASS_EN: i_bypass=1 on block 0 and 0 on block 1 -> block 0 rows are output verbatim, block 1 is transposed.
